// File: rtl/ecc_err_mon.sv
// SECDED error monitor: saturating per-class counters, first/most-severe capture,
// sticky interrupts and a small scrub write-back queue with valid/ready output.
module ecc_err_mon #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [1:0]            in_err_sts,
   input  logic                  clr,
   input  logic [CNT_WIDTH-1:0]  cnt_thresh,
   output logic                  scrub_valid,
   input  logic                  scrub_ready,
   output logic [ADDR_WIDTH-1:0] scrub_addr,
   output logic [DATA_WIDTH-1:0] scrub_data,
   output logic [CNT_WIDTH-1:0]  cnt_sbe,
   output logic [CNT_WIDTH-1:0]  cnt_ecc,
   output logic [CNT_WIDTH-1:0]  cnt_mbe,
   output logic                  cap_valid,
   output logic [ADDR_WIDTH-1:0] cap_addr,
   output logic [1:0]            cap_sts,
   output logic                  irq_mbe,
   output logic                  irq_thresh,
   output logic                  scrub_ovf
);

   localparam int PW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CNT_WIDTH + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } scrub_t;

   // Entry 0 is the head and drives the scrub outputs directly; pops shift down.
   scrub_t [FIFO_DEPTH-1:0] q_q, q_d;
   logic [PW-1:0]           fcnt_q, fcnt_d, widx;
   logic                    vld_q, vld_d;
   logic                    push, pop, full, acc, drop, ev;

   logic [CNT_WIDTH-1:0]  sbe_q, sbe_d, ecc_q, ecc_d, mbe_q, mbe_d;
   logic                  capv_q, capv_d, irqm_q, irqm_d, irqt_q, irqt_d, ovf_q, ovf_d;
   logic [ADDR_WIDTH-1:0] capa_q, capa_d;
   logic [1:0]            caps_q, caps_d;
   logic [SW-1:0]         sum;

   always_comb begin
      push   = in_valid && (in_err_sts == 2'b01 || in_err_sts == 2'b10);
      pop    = vld_q && scrub_ready;
      full   = (fcnt_q == PW'(FIFO_DEPTH));
      acc    = push && (!full || pop);
      drop   = push && full && !pop;
      widx   = fcnt_q - PW'(pop);
      q_d    = q_q;
      if (pop) begin
         for (int i = 0; i < FIFO_DEPTH - 1; i++) q_d[i] = q_q[i+1];
      end
      if (acc) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (PW'(i) == widx) q_d[i] = {in_addr, in_data};
         end
      end
      fcnt_d = fcnt_q + PW'(acc) - PW'(pop);
      vld_d  = (fcnt_d != '0);
   end

   always_comb begin
      ev     = in_valid && (in_err_sts != 2'b00);
      sbe_d  = sbe_q;
      ecc_d  = ecc_q;
      mbe_d  = mbe_q;
      capv_d = capv_q;
      capa_d = capa_q;
      caps_d = caps_q;
      irqm_d = irqm_q;
      ovf_d  = ovf_q || drop;
      if (ev) begin
         if (in_err_sts == 2'b01 && sbe_q != '1) sbe_d = sbe_q + CNT_WIDTH'(1);
         if (in_err_sts == 2'b10 && ecc_q != '1) ecc_d = ecc_q + CNT_WIDTH'(1);
         if (in_err_sts == 2'b11 && mbe_q != '1) mbe_d = mbe_q + CNT_WIDTH'(1);
         if (in_err_sts == 2'b11) irqm_d = 1'b1;
         // First error wins, except a multi-bit error replaces a milder one.
         if (!capv_q || (caps_q != 2'b11 && in_err_sts == 2'b11)) begin
            capv_d = 1'b1;
            capa_d = in_addr;
            caps_d = in_err_sts;
         end
      end
      sum    = SW'(sbe_d) + SW'(ecc_d);
      irqt_d = irqt_q || (cnt_thresh != '0 && sum >= SW'(cnt_thresh));
      if (clr) begin
         sbe_d  = '0;
         ecc_d  = '0;
         mbe_d  = '0;
         capv_d = 1'b0;
         capa_d = '0;
         caps_d = '0;
         irqm_d = 1'b0;
         irqt_d = 1'b0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         fcnt_q <= '0;
         vld_q  <= 1'b0;
         sbe_q  <= '0;
         ecc_q  <= '0;
         mbe_q  <= '0;
         capv_q <= 1'b0;
         capa_q <= '0;
         caps_q <= '0;
         irqm_q <= 1'b0;
         irqt_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         fcnt_q <= fcnt_d;
         vld_q  <= vld_d;
         sbe_q  <= sbe_d;
         ecc_q  <= ecc_d;
         mbe_q  <= mbe_d;
         capv_q <= capv_d;
         capa_q <= capa_d;
         caps_q <= caps_d;
         irqm_q <= irqm_d;
         irqt_q <= irqt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign scrub_valid = vld_q;
   assign scrub_addr  = q_q[0].addr;
   assign scrub_data  = q_q[0].data;
   assign cnt_sbe     = sbe_q;
   assign cnt_ecc     = ecc_q;
   assign cnt_mbe     = mbe_q;
   assign cap_valid   = capv_q;
   assign cap_addr    = capa_q;
   assign cap_sts     = caps_q;
   assign irq_mbe     = irqm_q;
   assign irq_thresh  = irqt_q;
   assign scrub_ovf   = ovf_q;

endmodule

// File: tb/tb_ecc_err_mon.sv
// Directed bench for ecc_err_mon (CNT_WIDTH = 4 so saturation is reachable).
module tb_ecc_err_mon;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, in_valid, clr, scrub_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic [1:0]    in_err_sts;
   logic [CW-1:0] cnt_thresh;
   logic          scrub_valid, cap_valid, irq_mbe, irq_thresh, scrub_ovf;
   logic [AW-1:0] scrub_addr, cap_addr;
   logic [DW-1:0] scrub_data;
   logic [CW-1:0] cnt_sbe, cnt_ecc, cnt_mbe;
   logic [1:0]    cap_sts;

   int n_assert = 0;
   int n_fail   = 0;
   int npop;
   logic [AW-1:0] last_addr;

   ecc_err_mon #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
      .in_err_sts(in_err_sts), .clr(clr), .cnt_thresh(cnt_thresh),
      .scrub_valid(scrub_valid), .scrub_ready(scrub_ready), .scrub_addr(scrub_addr),
      .scrub_data(scrub_data), .cnt_sbe(cnt_sbe), .cnt_ecc(cnt_ecc), .cnt_mbe(cnt_mbe),
      .cap_valid(cap_valid), .cap_addr(cap_addr), .cap_sts(cap_sts), .irq_mbe(irq_mbe),
      .irq_thresh(irq_thresh), .scrub_ovf(scrub_ovf));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sts, input logic [AW-1:0] a, input logic [DW-1:0] d);
      in_valid   = 1'b1;
      in_err_sts = sts;
      in_addr    = a;
      in_data    = d;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_err_sts = 2'b00;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; scrub_ready = 1'b0; cnt_thresh = '0;
      in_valid = 1'b0; in_addr = '0; in_data = '0; in_err_sts = 2'b00;
      tick(); tick();
      rst = 1'b0;
      chk("rst_scrub_valid", scrub_valid, 0);
      chk("rst_cnt_sbe", cnt_sbe, 0);
      chk("rst_cap_valid", cap_valid, 0);
      chk("rst_irqs", {irq_mbe, irq_thresh, scrub_ovf}, 0);

      // Clean words are ignored
      for (int i = 0; i < 10; i++) begin
         drive(2'b00, AW'(i * 8), 64'h1234 + DW'(i));
         tick();
         chk("clean_scrub_valid", scrub_valid, 0);
      end
      idle();
      chk("clean_counts", {cnt_sbe, cnt_ecc, cnt_mbe}, 0);
      chk("clean_cap_valid", cap_valid, 0);

      // Single correctable error, accepted immediately
      scrub_ready = 1'b1;
      drive(2'b01, 32'h100, 64'hDEAD_BEEF);
      tick();
      idle();
      chk("sbe_cnt", cnt_sbe, 1);
      chk("sbe_cap", {cap_valid, cap_sts, cap_addr}, {1'b1, 2'b01, 32'h100});
      chk("sbe_scrub_valid", scrub_valid, 1);
      chk("sbe_scrub_addr", scrub_addr, 32'h100);
      chk("sbe_scrub_data", scrub_data, 64'hDEAD_BEEF);
      tick();
      chk("sbe_accepted", scrub_valid, 0);
      pulse_clr();
      chk("clr_cnt", cnt_sbe, 0);
      chk("clr_cap", cap_valid, 0);

      // Severity upgrade; multi-bit errors never scrub
      npop = 0; last_addr = '0;
      drive(2'b01, 32'h10, 64'h10);
      tick();
      if (scrub_valid && scrub_ready) begin npop++; last_addr = scrub_addr; end
      drive(2'b11, 32'h20, 64'h20);
      tick();
      if (scrub_valid && scrub_ready) begin npop++; last_addr = scrub_addr; end
      drive(2'b11, 32'h30, 64'h30);
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         if (scrub_valid && scrub_ready) begin npop++; last_addr = scrub_addr; end
         tick();
      end
      chk("upg_cap", {cap_valid, cap_sts, cap_addr}, {1'b1, 2'b11, 32'h20});
      chk("upg_cnt_mbe", cnt_mbe, 2);
      chk("upg_cnt_sbe", cnt_sbe, 1);
      chk("upg_irq_mbe", irq_mbe, 1);
      chk("upg_npop", npop, 1);
      chk("upg_pop_addr", last_addr, 32'h10);
      pulse_clr();
      chk("clr_irq_mbe", irq_mbe, 0);

      // Queue overflow under stall, then in-order drain with stalls
      scrub_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(2'b10, AW'(k), 64'hA000 + DW'(k));
         tick();
      end
      idle();
      chk("ovf_flag", scrub_ovf, 1);
      chk("ovf_cnt_ecc", cnt_ecc, 6);
      chk("ovf_thresh_disabled", irq_thresh, 0);
      for (int k = 0; k < 4; k++) begin
         scrub_ready = 1'b0;
         tick();
         chk("drain_stall_valid", scrub_valid, 1);
         chk("drain_stall_addr", scrub_addr, k);
         scrub_ready = 1'b1;
         chk("drain_data", scrub_data, 64'hA000 + k);
         tick();
      end
      chk("drain_empty", scrub_valid, 0);
      pulse_clr();
      chk("clr_ovf", scrub_ovf, 0);

      // Threshold interrupt, then clr with a simultaneous event
      cnt_thresh = 4'd3;
      drive(2'b01, 32'h40, 64'h40);
      tick();
      chk("thr_after1", irq_thresh, 0);
      drive(2'b10, 32'h44, 64'h44);
      tick();
      chk("thr_after2", irq_thresh, 0);
      drive(2'b01, 32'h48, 64'h48);
      tick();
      chk("thr_after3", irq_thresh, 1);
      drive(2'b01, 32'h55, 64'h55);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      idle();
      chk("clrev_counts", {cnt_sbe, cnt_ecc, cnt_mbe}, 0);
      chk("clrev_irqs", {irq_thresh, irq_mbe}, 0);
      chk("clrev_cap", cap_valid, 0);
      chk("clrev_scrub_valid", scrub_valid, 1);
      chk("clrev_scrub_addr", scrub_addr, 32'h55);
      tick();
      chk("clrev_drained", scrub_valid, 0);

      // Saturation with sustained one-per-cycle scrub traffic
      cnt_thresh = '0;
      for (int k = 0; k < 20; k++) begin
         drive(2'b01, AW'(32'h200 + k), DW'(k));
         tick();
         if (k == 14) chk("sat_at15", cnt_sbe, 15);
      end
      idle();
      chk("sat_hold", cnt_sbe, 15);
      chk("sat_no_ovf", scrub_ovf, 0);
      chk("sat_last_scrub", scrub_addr, 32'h213);

      // Reset discards a pending request
      tick();
      scrub_ready = 1'b0;
      drive(2'b10, 32'h77, 64'h77);
      tick();
      idle();
      chk("rstmid_pending", scrub_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_valid", scrub_valid, 0);
      chk("rstmid_counts", {cnt_sbe, cnt_ecc}, 0);
      tick();
      chk("rstmid_stays_empty", scrub_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ecc_err_mon.md
# ecc_err_mon

Error monitor and scrub-request generator sitting directly downstream of the 64-bit SECDED decoder. It consumes each decoded word with its 2-bit error status and the address it was read from. It keeps saturating per-class error counters, captures the first (or most severe) error for software, and raises interrupts. It also queues write-back scrub requests, carrying corrected data, toward the memory controller over a valid/ready handshake.

## Interface
- ADDR_WIDTH, 32, read address width
- DATA_WIDTH, 64, data word width (matches decoder output)
- CNT_WIDTH, 16, width of each error counter
- FIFO_DEPTH, 4, scrub request queue depth (power of 2, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded word valid, one word per cycle, no backpressure
- in_addr  in  ADDR_WIDTH  address of decoded word
- in_data  in  DATA_WIDTH  decoder data output (already corrected when status = 01)
- in_err_sts  in  2  decoder status: 00 none, 01 single-bit corrected, 10 ECC-bit error, 11 multi-bit
- clr  in  1  single-cycle pulse; clears counters, capture, irqs, scrub_ovf
- cnt_thresh  in  CNT_WIDTH  correctable-error interrupt threshold; 0 disables
- scrub_valid  out  1  scrub request pending
- scrub_ready  in  1  memory controller accepts request
- scrub_addr  out  ADDR_WIDTH  scrub write address
- scrub_data  out  DATA_WIDTH  scrub write data
- cnt_sbe  out  CNT_WIDTH  count of status 01
- cnt_ecc  out  CNT_WIDTH  count of status 10
- cnt_mbe  out  CNT_WIDTH  count of status 11
- cap_valid  out  1  capture registers hold an error
- cap_addr  out  ADDR_WIDTH  captured address
- cap_sts  out  2  captured status
- irq_mbe  out  1  sticky: a multi-bit error was seen
- irq_thresh  out  1  sticky: cnt_sbe + cnt_ecc reached cnt_thresh
- scrub_ovf  out  1  sticky: scrub request dropped on full queue

## Operation
- An event is in_valid = 1 with in_err_sts != 00. Status 00 and in_valid = 0 cycles are ignored.
- Counters:
  - 01 increments cnt_sbe, 10 increments cnt_ecc, 11 increments cnt_mbe.
  - Each counter saturates at all-ones and never wraps.
- Scrub:
  - Status 01 and 10 push {in_addr, in_data} into the FIFO. Rewriting a 10 word regenerates its ECC.
  - Status 11 never pushes; the data is unrecoverable.
- FIFO full:
  - A push while full with no pop in the same cycle is dropped and sets scrub_ovf.
  - A push while full with a pop in the same cycle is accepted.
- Capture:
  - If cap_valid = 0, an event loads cap_addr and cap_sts and sets cap_valid.
  - If cap_valid = 1 and cap_sts != 11, a status-11 event overwrites cap_addr and cap_sts (severity upgrade).
  - All other events leave the capture unchanged.
- irq_mbe: sets on any status-11 event.
- irq_thresh:
  - Sets when cnt_thresh != 0 and the saturating sum cnt_sbe + cnt_ecc after the update is >= cnt_thresh.
  - The sum is computed in CNT_WIDTH+1 bits.
- clr:
  - Zeroes all counters, capture, irq_mbe, irq_thresh and scrub_ovf.
  - clr has priority: an event in the same cycle is not counted or captured, but its scrub push still occurs.
  - The FIFO is not flushed by clr.

## Timing
- All outputs are registered.
- Reset value of every output is 0, and the FIFO is empty.
- Event at cycle N: counters, capture, irqs and scrub_ovf update at N+1.
- Push into an empty FIFO at N: scrub_valid = 1 with the entry at N+1.
- Handshake:
  - scrub_valid, scrub_addr and scrub_data stay stable until the cycle scrub_valid & scrub_ready.
  - The next entry, if any, is presented in the following cycle.
  - scrub_valid never drops without acceptance except on rst.
- Sustained throughput: one accepted request per cycle.
- rst mid-transfer: the pending request is discarded and scrub_valid = 0 the next cycle.

## Test plan
- rst, then in_valid with status 00 for 10 cycles -> all counters 0, cap_valid 0, scrub_valid never 1.
- Status 01 at addr 0x100, data 0xDEAD_BEEF, scrub_ready = 1 -> next cycle cnt_sbe = 1, cap_addr = 0x100, cap_sts = 01, scrub_valid = 1 with scrub_addr 0x100 and scrub_data 0xDEADBEEF, accepted the same cycle.
- Status 01 at 0x10, then status 11 at 0x20, then 11 at 0x30 -> cap_addr = 0x20, cap_sts = 11, cnt_mbe = 2, irq_mbe = 1, exactly one scrub request.
- scrub_ready = 0, 6 consecutive status-10 events -> 4 queued, scrub_ovf = 1. Then raise ready -> 4 requests in order at addrs 0..3, each held stable while stalled.
- cnt_thresh = 3; events 01, 10, 01 -> irq_thresh rises the cycle after the third event. Then clr with a simultaneous status-01 event -> counters and irqs 0, one new scrub request still queued.
- Force cnt_sbe to saturate with CNT_WIDTH = 4 (20 status-01 events) -> cnt_sbe holds 15.
